// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: shares one burst-mode memory port between the L1 I-cache and D-cache,
// holding the command for a whole burst and inserting a turnaround cycle between bursts.
module l1_mem_arbiter #(
    parameter int BURST_LEN   = 4,
    parameter int BURST_WIDTH = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int TIMEOUT     = 1024,
    localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_read,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    output logic [BURST_WIDTH-1:0] i_rdata,
    output logic                   i_resp,
    input  logic                   d_read,
    input  logic                   d_write,
    input  logic [ADDR_WIDTH-1:0]  d_addr,
    input  logic [BURST_WIDTH-1:0] d_wdata,
    input  logic [3:0]             d_byte_en,
    output logic [BURST_WIDTH-1:0] d_rdata,
    output logic                   d_resp,
    output logic [BW-1:0]          beat_idx,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    output logic [BURST_WIDTH-1:0] mem_wdata,
    output logic [3:0]             mem_byte_enable,
    input  logic [BURST_WIDTH-1:0] mem_rdata,
    input  logic                   mem_resp,
    input  logic                   pm_error,
    output logic                   err
);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, TURN} state_e;

    state_e                state_q, state_d;
    logic                  last_d_q, last_d_d;
    logic                  err_q, err_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [WW-1:0]         wd_q, wd_d;
    logic                  busy, d_illegal, d_valid, grant_i, grant_d, last_beat, timeout, abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b1;
            err_q       <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            beat_q      <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            err_q       <= err_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            beat_q      <= beat_d;
            wd_q        <= wd_d;
        end
    end

    // Round-robin: on a tie, I wins only if D was granted last.
    always_comb begin
        busy      = state_q inside {I_RD, D_RD, D_WR};
        d_illegal = d_read & d_write;
        d_valid   = (d_read | d_write) & ~d_illegal;
        grant_i   = (state_q == IDLE) & i_read & (~d_valid | last_d_q);
        grant_d   = (state_q == IDLE) & d_valid & ~grant_i;
        last_beat = mem_resp & (beat_q == BW'(BURST_LEN - 1));
        timeout   = ~mem_resp & (wd_q == WW'(TIMEOUT - 1));
        abort     = busy & (pm_error | timeout);
        unique case (state_q)
            IDLE:    state_d = grant_i ? I_RD : grant_d ? (d_write ? D_WR : D_RD) : IDLE;
            TURN:    state_d = IDLE;
            default: state_d = (abort | last_beat) ? TURN : state_q;
        endcase
    end

    always_comb begin
        mem_read_d  = state_d inside {I_RD, D_RD};
        mem_write_d = state_d == D_WR;
        addr_d      = grant_i ? i_addr : grant_d ? d_addr : addr_q;
        be_d        = (grant_d & d_write) ? d_byte_en : (grant_i | grant_d) ? 4'hF : be_q;
        last_d_d    = grant_d | (last_d_q & ~grant_i);
        beat_d      = (~busy | abort | last_beat) ? '0 : beat_q + BW'(mem_resp);
        wd_d        = (busy & ~mem_resp) ? wd_q + 1'b1 : '0;
        err_d       = err_q | pm_error | ((state_q == IDLE) & d_illegal) | (busy & timeout);
        i_resp      = (state_q == I_RD) & mem_resp;
        d_resp      = (state_q inside {D_RD, D_WR}) & mem_resp;
        mem_wdata   = (state_q == D_WR) ? d_wdata : '0;
    end

    assign i_rdata         = mem_rdata;
    assign d_rdata         = mem_rdata;
    assign beat_idx        = beat_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_address     = addr_q;
    assign mem_byte_enable = be_q;
    assign err             = err_q;
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb_l1_mem_arbiter: scenario tasks against a burst memory model; read beats are
// checked through an expected-beat queue filled when each request is issued.
module tb_l1_mem_arbiter;
    localparam int BL = 4;
    localparam int TO = 16;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, wmode = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata, i_rdata, d_rdata, mem_address, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [3:0]  d_byte_en = '0, mem_byte_enable;
    logic [1:0]  beat_idx;
    logic        i_resp, d_resp, mem_read, mem_write, err;
    logic        mem_resp = 1'b0, pm_error = 1'b0;

    typedef struct {bit is_i; logic [31:0] data; logic [1:0] beat;} exp_t;
    exp_t        sb[$];
    logic [31:0] mem[int unsigned];
    int          vectors = 0, miscompares = 0, mcnt = 0;
    bit          stall = 1'b0;

    assign d_wdata = wmode ? 32'hA0 + 32'(beat_idx) : 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    l1_mem_arbiter #(.BURST_LEN(BL), .BURST_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byte_en(d_byte_en), .d_rdata(d_rdata), .d_resp(d_resp), .beat_idx(beat_idx),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .pm_error(pm_error), .err(err)
    );

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : a ^ 32'hC0DE_0000;
    endfunction

    task automatic push_line(input bit is_i, input logic [31:0] a, input bit wr);
        for (int k = 0; k < BL; k++)
            sb.push_back(exp_t'{is_i, wr ? 32'h0 : rd(a + 32'(4 * k)), 2'(k)});
    endtask

    // Memory model: answers one beat per cycle while a command is held, unless stalled.
    always @(posedge clk) begin
        if (rst_n && mem_resp) begin
            if (mem_write) mem[mem_address + 32'(4 * mcnt)] = mem_wdata;
            mcnt = (mcnt + 1) % BL;
        end
        #1;
        if (!rst_n) mcnt = 0;
        mem_resp  = rst_n && (mem_read || mem_write) && !stall;
        mem_rdata = (mem_resp && mem_read) ? rd(mem_address + 32'(4 * mcnt)) : 32'h0;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (i_resp || d_resp) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL resp_unexpected: i_resp=%0b d_resp=%0b beat=%0d, required no beat", i_resp, d_resp, beat_idx);
            end else begin
                e = sb.pop_front();
                if ({i_resp, d_resp, beat_idx, (i_resp ? i_rdata : d_rdata)} !== {e.is_i, !e.is_i, e.beat, e.data}) begin
                    miscompares++;
                    $display("FAIL resp_beat: got i=%0b d=%0b beat=%0d data=%h, required i=%0b d=%0b beat=%0d data=%h",
                             i_resp, d_resp, beat_idx, (i_resp ? i_rdata : d_rdata), e.is_i, !e.is_i, e.beat, e.data);
                end
            end
        end
    end

    task automatic apply_reset();
        i_read = 0; d_read = 0; d_write = 0; wmode = 0; stall = 0; rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        sb.delete();
    endtask

    // Returns at the first negedge where the command level matches; n counts earlier negedges.
    task automatic wait_cmd(input bit level, output int n);
        n = 0;
        @(negedge clk);
        while ((mem_read || mem_write) != level && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({mem_read, mem_write, i_resp, d_resp, err} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: rd=%0b wr=%0b iresp=%0b dresp=%0b err=%0b, required all 0", mem_read, mem_write, i_resp, d_resp, err);
        end
        vectors++;
        if ({mem_address, mem_byte_enable, beat_idx} !== 38'h0) begin
            miscompares++;
            $display("FAIL reset_data: addr=%h be=%h beat=%0d, required 0", mem_address, mem_byte_enable, beat_idx);
        end
    endtask

    task automatic test_i_read();
        int n;
        @(negedge clk);
        i_read = 1; i_addr = 32'h100;
        push_line(1, 32'h100, 0);
        @(posedge clk); #1;
        i_read = 0;
        vectors++;
        if ({mem_read, mem_write, mem_address, mem_byte_enable} !== {2'b10, 32'h100, 4'hF}) begin
            miscompares++;
            $display("FAIL i_grant: rd=%0b wr=%0b addr=%h be=%h, required 1 0 00000100 f", mem_read, mem_write, mem_address, mem_byte_enable);
        end
        wait_cmd(0, n);
        vectors++;
        if (n !== BL) begin
            miscompares++;
            $display("FAIL i_burst_len: cmd cycles=%0d, required %0d", n, BL);
        end
        vectors++;
        if (sb.size() !== 0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL i_done: pending=%0d err=%0b, required 0 0", sb.size(), err);
        end
    endtask

    task automatic test_d_write();
        int n;
        @(negedge clk);
        d_write = 1; d_addr = 32'h2000; d_byte_en = 4'hF; wmode = 1;
        push_line(0, 32'h2000, 1);
        @(posedge clk); #1;
        d_write = 0;
        vectors++;
        if ({mem_read, mem_write, mem_byte_enable} !== {2'b01, 4'hF}) begin
            miscompares++;
            $display("FAIL d_grant: rd=%0b wr=%0b be=%h, required 0 1 f", mem_read, mem_write, mem_byte_enable);
        end
        for (int k = 0; k < BL; k++) begin
            @(negedge clk);
            vectors++;
            if (mem_address !== 32'h2000 || mem_write !== 1'b1) begin
                miscompares++;
                $display("FAIL d_hold%0d: addr=%h wr=%0b, required 00002000 1", k, mem_address, mem_write);
            end
        end
        wait_cmd(0, n);
        wmode = 0;
        for (int k = 0; k < BL; k++) begin
            vectors++;
            if (rd(32'h2000 + 32'(4 * k)) !== 32'hA0 + 32'(k)) begin
                miscompares++;
                $display("FAIL d_mem%0d: got %h, required %h", k, rd(32'h2000 + 32'(4 * k)), 32'hA0 + 32'(k));
            end
        end
        vectors++;
        if (err !== 1'b0 || sb.size() !== 0) begin
            miscompares++;
            $display("FAIL d_done: err=%0b pending=%0d, required 0 0", err, sb.size());
        end
    endtask

    task automatic test_round_robin();
        int n;
        apply_reset();
        @(negedge clk);
        i_read = 1; i_addr = 32'h300; d_read = 1; d_addr = 32'h400;
        push_line(1, 32'h300, 0);
        push_line(0, 32'h400, 0);
        @(posedge clk); #1;
        i_read = 0;
        vectors++;
        if (mem_read !== 1'b1 || mem_address !== 32'h300) begin
            miscompares++;
            $display("FAIL rr_first: rd=%0b addr=%h, required 1 00000300", mem_read, mem_address);
        end
        wait_cmd(0, n);
        wait_cmd(1, n);
        d_read = 0;
        vectors++;
        if (n !== 1 || mem_address !== 32'h400) begin
            miscompares++;
            $display("FAIL rr_second: gap=%0d addr=%h, required 1 00000400", n + 1, mem_address);
        end
        wait_cmd(0, n);
        @(negedge clk);
        i_read = 1; i_addr = 32'h700;
        push_line(1, 32'h700, 0);
        @(posedge clk); #1;
        i_read = 0;
        wait_cmd(0, n);
        @(negedge clk);
        i_read = 1; i_addr = 32'h900; d_read = 1; d_addr = 32'h800;
        push_line(0, 32'h800, 0);
        push_line(1, 32'h900, 0);
        @(posedge clk); #1;
        d_read = 0;
        vectors++;
        if (mem_read !== 1'b1 || mem_address !== 32'h800) begin
            miscompares++;
            $display("FAIL rr_d_first: rd=%0b addr=%h, required 1 00000800", mem_read, mem_address);
        end
        wait_cmd(0, n);
        wait_cmd(1, n);
        i_read = 0;
        vectors++;
        if (mem_address !== 32'h900) begin
            miscompares++;
            $display("FAIL rr_i_next: addr=%h, required 00000900", mem_address);
        end
        wait_cmd(0, n);
    endtask

    task automatic test_illegal();
        int n;
        apply_reset();
        @(negedge clk);
        d_read = 1; d_write = 1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({err, mem_read, mem_write} !== 3'b100) begin
            miscompares++;
            $display("FAIL illegal: err=%0b rd=%0b wr=%0b, required 1 0 0", err, mem_read, mem_write);
        end
        @(negedge clk);
        d_read = 0; d_write = 0; i_read = 1; i_addr = 32'h140;
        push_line(1, 32'h140, 0);
        @(posedge clk); #1;
        i_read = 0;
        vectors++;
        if (mem_read !== 1'b1 || mem_address !== 32'h140 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_after: rd=%0b addr=%h err=%0b, required 1 00000140 1", mem_read, mem_address, err);
        end
        wait_cmd(0, n);
    endtask

    task automatic test_timeout();
        int n;
        apply_reset();
        stall = 1;
        @(negedge clk);
        i_read = 1; i_addr = 32'h40;
        @(posedge clk); #1;
        i_read = 0;
        wait_cmd(0, n);
        vectors++;
        if (n !== TO || err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout: cmd cycles=%0d err=%0b, required %0d 1", n, err, TO);
        end
        stall = 0;
        @(negedge clk);
        i_read = 1; i_addr = 32'h80;
        push_line(1, 32'h80, 0);
        @(posedge clk); #1;
        i_read = 0;
        vectors++;
        if (mem_read !== 1'b1 || mem_address !== 32'h80) begin
            miscompares++;
            $display("FAIL timeout_recover: rd=%0b addr=%h, required 1 00000080", mem_read, mem_address);
        end
        wait_cmd(0, n);
    endtask

    task automatic test_reset_mid();
        int n;
        apply_reset();
        @(negedge clk);
        d_read = 1; d_addr = 32'h1000;
        push_line(0, 32'h1000, 0);
        @(posedge clk); #1;
        d_read = 0;
        n = 0;
        while (beat_idx !== 2'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1 rst_n = 0;
        #1;
        vectors++;
        if (n >= 20 || {mem_read, mem_write, i_resp, d_resp, mem_address, mem_byte_enable, beat_idx} !== 42'h0) begin
            miscompares++;
            $display("FAIL reset_mid: waited=%0d rd=%0b wr=%0b iresp=%0b dresp=%0b addr=%h be=%h beat=%0d, required all 0",
                     n, mem_read, mem_write, i_resp, d_resp, mem_address, mem_byte_enable, beat_idx);
        end
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        i_read = 1; i_addr = 32'h180; d_read = 1; d_addr = 32'h1C0;
        push_line(1, 32'h180, 0);
        push_line(0, 32'h1C0, 0);
        @(posedge clk); #1;
        i_read = 0;
        vectors++;
        if (mem_read !== 1'b1 || mem_address !== 32'h180 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_regrant: rd=%0b addr=%h err=%0b, required 1 00000180 0", mem_read, mem_address, err);
        end
        wait_cmd(0, n);
        wait_cmd(1, n);
        d_read = 0;
        vectors++;
        if (mem_address !== 32'h1C0) begin
            miscompares++;
            $display("FAIL reset_d_next: addr=%h, required 000001c0", mem_address);
        end
        wait_cmd(0, n);
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_round_robin();
        test_illegal();
        test_timeout();
        test_reset_mid();
        repeat (2) @(negedge clk);
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL beats_missing: pending=%0d, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end
endmodule

// File: doc/l1_mem_arbiter.md
Name: l1_mem_arbiter

Overview:
- Shares the single burst-mode main-memory port between the L1 instruction cache (read-only) and the L1 data cache (read and write).
- Grants one requester at a time and holds address and command stable for the whole burst.
- Counts response beats, inserts one turnaround cycle so memory never sees a back-to-back command, and flags protocol and memory errors.
- Sits between the two L1 caches and the memory model's mem_itf.

Parameters:
- BURST_LEN, 4, beats per cache-line transfer.
- BURST_WIDTH, 32, bits per beat (equal to the mem_rdata/mem_wdata width).
- ADDR_WIDTH, 32, address width.
- TIMEOUT, 1024, max busy cycles without mem_resp before abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_read  in  1  I-cache line read request (level).
- i_addr  in  ADDR_WIDTH  I-cache line address.
- i_rdata  out  BURST_WIDTH  read beat data to I-cache.
- i_resp  out  1  I-cache beat valid.
- d_read  in  1  D-cache line read request (level).
- d_write  in  1  D-cache line write request (level).
- d_addr  in  ADDR_WIDTH  D-cache line address.
- d_wdata  in  BURST_WIDTH  D-cache write beat data, indexed by beat_idx.
- d_byte_en  in  4  D-cache byte enables.
- d_rdata  out  BURST_WIDTH  read beat data to D-cache.
- d_resp  out  1  D-cache beat valid.
- beat_idx  out  $clog2(BURST_LEN)  current beat number of the active burst.
- mem_read  out  1  memory read command.
- mem_write  out  1  memory write command.
- mem_address  out  ADDR_WIDTH  memory address.
- mem_wdata  out  BURST_WIDTH  memory write data.
- mem_byte_enable  out  4  memory byte enables.
- mem_rdata  in  BURST_WIDTH  memory read data.
- mem_resp  in  1  memory beat response.
- pm_error  in  1  memory protocol error.
- err  out  1  sticky error flag.

Behaviour:
- Reset: async on rst_n low. State IDLE, beat count 0, last_grant = D, err 0. mem_read, mem_write, mem_address, mem_byte_enable, i_resp and d_resp are all 0.
- States: IDLE, I_RD, D_RD, D_WR, TURN.
- IDLE arbitration, sampled at the clock edge:
  - Only one valid request pending: grant it.
  - I and D both pending: grant the requester other than last_grant (I wins first after reset).
  - d_read and d_write both high: illegal. Set err; the D request is not granted that cycle, and I may still be granted.
- On grant: register mem_address (requester's addr), mem_read or mem_write, and mem_byte_enable (d_byte_en, or 4'hF for reads); update last_grant. Command is visible the cycle after the request is sampled (1-cycle latency).
- Busy states (I_RD/D_RD/D_WR):
  - Registered mem_* outputs stay constant; requester inputs are ignored, and dropping a request mid-burst does not shorten the burst.
  - beat_idx increments on each cycle with mem_resp=1.
  - mem_resp high with beat_idx==BURST_LEN-1: go to TURN, clear mem_read/mem_write at that edge, reset beat_idx to 0.
- Data routing, combinational:
  - i_rdata = d_rdata = mem_rdata always.
  - i_resp = mem_resp in I_RD, else 0; d_resp = mem_resp in D_RD or D_WR, else 0.
  - mem_wdata = d_wdata in D_WR, else 0. D-cache supplies the word selected by beat_idx; memory samples it one cycle after each resp edge.
- TURN: exactly one cycle with no command, then IDLE. Pending requests are evaluated in IDLE, so consecutive bursts are separated by at least 2 command-free cycles.
- Watchdog: a cycle counter resets on each mem_resp and on entry to a busy state. Reaching TIMEOUT sets err, drops the command and goes to TURN.
- pm_error high in any state sets err; from a busy state, abort to TURN.
- err is sticky until rst_n.
- mem_resp in IDLE or TURN is ignored and not forwarded.
- Reset mid-burst clears everything immediately; the memory side may report an error, which is accepted.

Test Plan:
- Single I read, i_addr=0x100, BURST_LEN=4 -> mem_read=1, mem_address=0x100 one cycle later. i_resp pulses 4 cycles with beat_idx 0..3 and i_rdata = memory words 0x100..0x10C. mem_read=0 in TURN; d_resp stays 0.
- D write, d_addr=0x2000, d_byte_en=4'hF, d_wdata=beat_idx+0xA0 -> memory line at 0x2000 holds 0xA0..0xA3. err=0; mem_address constant through the burst.
- i_read and d_read asserted on the same edge after reset -> I granted first. D granted after I's 4 beats plus TURN. Next simultaneous pair -> D first (round-robin).
- d_read=d_write=1 with i_read=0 -> err=1, no command issued, state stays IDLE.
- Memory stalled (never asserts mem_resp) with TIMEOUT=16 -> err=1 and mem_read cleared 16 cycles after grant; state returns to IDLE after TURN.
- rst_n pulled low at beat 2 of a D read -> all mem_* outputs, resp lines and beat_idx are 0 immediately. After release, a new i_read is granted normally (I first).
